// File: rtl/appmsg_load_ctrl.sv
// APPmsg frame loader: primes the shared input ROMs, streams one frame per code block and
// waits for every block to be decoded. Optional stall counter: define APPMSG_STALL_CNT_EN.
module appmsg_load_ctrl #(
    parameter int SUBX_NUM  = 4,
    parameter int SHORT_LEN = 16,
    parameter int LONG_LEN  = 128,
    parameter int RD_LAT    = 2,
    parameter int BLK_NUM   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        buf_ready,
    input  logic        dec_valid,
    output logic [1:0]  rom_addr,
    output logic [1:0]  sub_x,
    output logic        buffer_valid,
    output logic        buffer_start,
    output logic        buffer_last,
    output logic [3:0]  blk_sent,
    output logic        busy,
    output logic        done
`ifdef APPMSG_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int FRAME_LEN = (SUBX_NUM - 1) * SHORT_LEN + LONG_LEN;
    localparam int BW        = $clog2(FRAME_LEN);
    localparam int PW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        PRIME,
        STREAM,
        WAIT_DEC,
        DONE
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat;
    logic [PW-1:0]   prime_cnt;
    logic [3:0]      dec_cnt;
    logic [3:0]      dec_cnt_nxt;
    logic            frame_end;
    logic            more_blocks;

    // Section holding a given beat; beats past the short sections all belong to the long one.
    function automatic logic [1:0] sec_of(input int b);
        if (b >= (SUBX_NUM - 1) * SHORT_LEN) return 2'(SUBX_NUM - 1);
        return 2'(b / SHORT_LEN);
    endfunction

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        dec_cnt_nxt = dec_cnt;
        if (dec_valid && dec_cnt != 4'(BLK_NUM)) dec_cnt_nxt = dec_cnt + 4'd1;
    end

    assign frame_end   = (beat == BW'(FRAME_LEN - 1));
    assign more_blocks = ({1'b0, blk_sent} + 5'd1) < 5'(BLK_NUM);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat         <= '0;
            prime_cnt    <= '0;
            dec_cnt      <= '0;
            blk_sent     <= '0;
            rom_addr     <= '0;
            sub_x        <= '0;
            buffer_valid <= 1'b0;
            buffer_start <= 1'b0;
            buffer_last  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (abort) begin
            state        <= IDLE;
            rom_addr     <= '0;
            sub_x        <= '0;
            buffer_valid <= 1'b0;
            buffer_start <= 1'b0;
            buffer_last  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (busy) dec_cnt <= dec_cnt_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= WAIT_RDY;
                        blk_sent <= '0;
                        dec_cnt  <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                WAIT_RDY: begin
                    if (buf_ready) begin
                        state     <= PRIME;
                        prime_cnt <= '0;
                        rom_addr  <= '0;
                    end
                end
                PRIME: begin
                    if (prime_cnt == PW'(RD_LAT - 1)) begin
                        state        <= STREAM;
                        beat         <= '0;
                        buffer_valid <= 1'b1;
                        buffer_start <= 1'b1;
                        buffer_last  <= (FRAME_LEN == 1);
                        sub_x        <= '0;
                        rom_addr     <= sec_of(RD_LAT);
                    end else begin
                        prime_cnt <= prime_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (frame_end) begin
                        state        <= more_blocks ? WAIT_RDY : WAIT_DEC;
                        blk_sent     <= blk_sent + 4'd1;
                        buffer_valid <= 1'b0;
                        buffer_start <= 1'b0;
                        buffer_last  <= 1'b0;
                        sub_x        <= '0;
                        rom_addr     <= '0;
                    end else begin
                        // rom_addr runs RD_LAT beats ahead so the ROM output lines up with sub_x.
                        beat         <= beat + 1'b1;
                        buffer_start <= 1'b0;
                        buffer_last  <= (beat == BW'(FRAME_LEN - 2));
                        sub_x        <= sec_of(int'(beat) + 1);
                        rom_addr     <= sec_of(int'(beat) + 1 + RD_LAT);
                    end
                end
                WAIT_DEC: begin
                    if (dec_cnt_nxt == 4'(BLK_NUM)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef APPMSG_STALL_CNT_EN
    // Counts cycles spent waiting on the decoder buffer during the current run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!abort && start && (state == IDLE || state == DONE)) begin
            stall_cnt <= '0;
        end else if (!abort && state == WAIT_RDY && !buf_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_appmsg_load_ctrl.sv
// Bench for appmsg_load_ctrl: frame table plus beat scoreboard on the RD_LAT=2 instance,
// ROM alignment models on RD_LAT=1/2/3 instances sharing the same stimulus.
module tb_appmsg_load_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic buf_ready = 1'b0;
    logic dec_valid = 1'b0;

    logic [1:0] rom_addr [3];
    logic [1:0] sub_x    [3];
    logic       bv       [3];
    logic       bs       [3];
    logic       bl       [3];
    logic [3:0] blk      [3];
    logic       busy     [3];
    logic       done     [3];
`ifdef APPMSG_STALL_CNT_EN
    logic [15:0] stall_cnt [3];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    appmsg_load_ctrl #(.RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .buf_ready(buf_ready), .dec_valid(dec_valid),
        .rom_addr(rom_addr[0]), .sub_x(sub_x[0]), .buffer_valid(bv[0]),
        .buffer_start(bs[0]), .buffer_last(bl[0]), .blk_sent(blk[0]),
        .busy(busy[0]), .done(done[0])
`ifdef APPMSG_STALL_CNT_EN
        , .stall_cnt(stall_cnt[0])
`endif
    );

    appmsg_load_ctrl #(.RD_LAT(1)) dut_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .buf_ready(buf_ready), .dec_valid(dec_valid),
        .rom_addr(rom_addr[1]), .sub_x(sub_x[1]), .buffer_valid(bv[1]),
        .buffer_start(bs[1]), .buffer_last(bl[1]), .blk_sent(blk[1]),
        .busy(busy[1]), .done(done[1])
`ifdef APPMSG_STALL_CNT_EN
        , .stall_cnt(stall_cnt[1])
`endif
    );

    appmsg_load_ctrl #(.RD_LAT(3)) dut_lat3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .buf_ready(buf_ready), .dec_valid(dec_valid),
        .rom_addr(rom_addr[2]), .sub_x(sub_x[2]), .buffer_valid(bv[2]),
        .buffer_start(bs[2]), .buffer_last(bl[2]), .blk_sent(blk[2]),
        .busy(busy[2]), .done(done[2])
`ifdef APPMSG_STALL_CNT_EN
        , .stall_cnt(stall_cnt[2])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ROM models: each returns its address after the instance's read latency.
    logic [1:0] rp [3][3];
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            rp[k][0] <= rom_addr[k];
            rp[k][1] <= rp[k][0];
            rp[k][2] <= rp[k][1];
        end
    end

    typedef struct packed {
        logic [1:0] sx;
        logic       st;
        logic       ls;
    } beat_t;
    beat_t sb_q[$];

    task automatic push_frame();
        beat_t e;
        for (int b = 0; b < 176; b++) begin
            e.sx = (b < 16) ? 2'd0 : (b < 32) ? 2'd1 : (b < 48) ? 2'd2 : 2'd3;
            e.st = (b == 0);
            e.ls = (b == 175);
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bv[0]) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid_beat", 32'(bv[0]), 32'd0);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    check("beat_sub_x_start_last", 32'({sub_x[0], bs[0], bl[0]}), 32'(e));
                end
            end
            if (bv[0]) check("rom_align_lat2", 32'(rp[0][1]), 32'(sub_x[0]));
            if (bv[1]) check("rom_align_lat1", 32'(rp[1][0]), 32'(sub_x[1]));
            if (bv[2]) check("rom_align_lat3", 32'(rp[2][2]), 32'(sub_x[2]));
        end
    end

    typedef struct {
        int gap;         // cycles of buf_ready low before the frame
        int hold;        // cycles buf_ready (and start) stay high
        bit with_start;
        int dec_at;      // pulse dec_valid when this many beats remain (-1: none)
        int start_at;    // pulse start mid-frame when this many beats remain (-1: none)
        int exp_blk;
    } frame_vec_t;

    task automatic run_frame(input frame_vec_t v);
        int cycles;
        bit seen;
        cycles = 0;
        seen = 1'b0;
        buf_ready = 1'b0;
        repeat (v.gap) begin
            @(posedge clk); #1;
        end
        push_frame();
        start = v.with_start;
        buf_ready = 1'b1;
        repeat (v.hold) begin
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
        end
        buf_ready = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk); #1;
            cycles++;
            dec_valid = 1'b0;
            start = 1'b0;
            if (!seen && bv[0]) begin
                seen = 1'b1;
                if (v.with_start) check("first_valid_latency", 32'(cycles), 32'd4);
            end
            if (sb_q.size() == 0) break;
            if (sb_q.size() == v.dec_at) dec_valid = 1'b1;
            if (sb_q.size() == v.start_at) start = 1'b1;
        end
        check("frame_completed", 32'(sb_q.size()), 32'd0);
        check("blk_sent_after_frame", 32'(blk[0]), 32'(v.exp_blk));
        check("busy_after_frame", 32'(busy[0]), 32'd1);
    endtask

    frame_vec_t vecs[8];
    frame_vec_t fv;
    int gap_sum;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Frame table for one full run; the 8th dec_valid lands on the last beat.
        vecs[0] = '{gap: 0,  hold: 2, with_start: 1, dec_at: 100, start_at: -1, exp_blk: 1};
        vecs[1] = '{gap: 10, hold: 1, with_start: 0, dec_at: 100, start_at: 150, exp_blk: 2};
        vecs[2] = '{gap: 10, hold: 1, with_start: 0, dec_at: 100, start_at: -1, exp_blk: 3};
        vecs[3] = '{gap: 4,  hold: 1, with_start: 0, dec_at: 100, start_at: -1, exp_blk: 4};
        vecs[4] = '{gap: 10, hold: 1, with_start: 0, dec_at: 100, start_at: -1, exp_blk: 5};
        vecs[5] = '{gap: 10, hold: 1, with_start: 0, dec_at: 100, start_at: -1, exp_blk: 6};
        vecs[6] = '{gap: 7,  hold: 1, with_start: 0, dec_at: 100, start_at: -1, exp_blk: 7};
        vecs[7] = '{gap: 10, hold: 1, with_start: 0, dec_at: 1,   start_at: -1, exp_blk: 8};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bv[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_blk_sent", 32'(blk[0]), 32'd0);
        check("rst_rom_addr", 32'(rom_addr[0]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy[0]), 32'd0);

        // Full run of eight frames
        gap_sum = 0;
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i]);
            gap_sum += vecs[i].gap;
        end
        check("wait_dec_done_low", 32'(done[0]), 32'd0);
        @(posedge clk); #1;
        check("done_after_wait_dec", 32'(done[0]), 32'd1);
        check("busy_in_done", 32'(busy[0]), 32'd0);
`ifdef APPMSG_STALL_CNT_EN
        check("stall_cnt_at_done", 32'(stall_cnt[0]), 32'(gap_sum));
`endif

        // DONE holds against dec_valid and buf_ready
        dec_valid = 1'b1;
        buf_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        dec_valid = 1'b0;
        buf_ready = 1'b0;
        check("done_holds", 32'(done[0]), 32'd1);
        check("done_blk_sent", 32'(blk[0]), 32'd8);

        // New run from DONE, then abort on beat 100 of frame 3 together with start
        fv = '{gap: 2, hold: 2, with_start: 1, dec_at: -1, start_at: -1, exp_blk: 1};
        run_frame(fv);
        fv = '{gap: 3, hold: 1, with_start: 0, dec_at: -1, start_at: -1, exp_blk: 2};
        run_frame(fv);
        repeat (3) begin
            @(posedge clk); #1;
        end
        push_frame();
        buf_ready = 1'b1;
        @(posedge clk); #1;
        buf_ready = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (sb_q.size() == 76) break;
            @(posedge clk); #1;
        end
        check("reached_beat_100", 32'(sb_q.size()), 32'd76);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        sb_q.delete();
        check("abort_valid", 32'(bv[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        @(posedge clk); #1;
        check("abort_stays_idle", 32'(busy[0]), 32'd0);
        fv = '{gap: 2, hold: 2, with_start: 1, dec_at: -1, start_at: -1, exp_blk: 1};
        run_frame(fv);

        // Reset mid-frame drops the frame for good
        push_frame();
        buf_ready = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < 400; t++) begin
            if (sb_q.size() == 120) break;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        sb_q.delete();
        check("async_rst_valid", 32'(bv[0]), 32'd0);
        check("async_rst_blk_sent", 32'(blk[0]), 32'd0);
        check("async_rst_busy", 32'(busy[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("no_resume_after_rst", 32'(busy[0]), 32'd0);
        buf_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/appmsg_load_ctrl.md
APPMSG_LOAD_CTRL -- requirements
Module: appmsg_load_ctrl

Interface
Parameters:
REQ-001 SHALL: SUBX_NUM, 4, number of sub-sections per frame.
REQ-002 SHALL: SHORT_LEN, 16, beats in each of sections 0..SUBX_NUM-2.
REQ-003 SHALL: LONG_LEN, 128, beats in the last section (frame = 3*16+128 = 176 beats at defaults).
REQ-004 SHALL: RD_LAT, 2, input-buffer ROM read latency in cycles (legal range 1..3).
REQ-005 SHALL: BLK_NUM, 8, code blocks per run.

Ports:
REQ-006 SHALL: clk  in  1  clock, rising edge.
REQ-007 SHALL: rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL: start  in  1  one-cycle run request.
REQ-009 SHALL: abort  in  1  synchronous run cancel.
REQ-010 SHALL: buf_ready  in  1  decoder input buffer can accept a frame.
REQ-011 SHALL: dec_valid  in  1  one-cycle pulse per decoded block.
REQ-012 SHALL: rom_addr  out  2  address to the eight APPmsg input ROMs (shared).
REQ-013 SHALL: sub_x  out  2  section index of the current beat.
REQ-014 SHALL: buffer_valid / buffer_start / buffer_last  out  1 each  frame beat qualifiers.
REQ-015 SHALL: blk_sent  out  4  frames fully streamed in this run.
REQ-016 SHALL: busy  out  1  high in any state except IDLE and DONE.
REQ-017 SHALL: done  out  1  level, high in DONE.

Function
REQ-018 SHALL: FSM states IDLE, WAIT_RDY, PRIME, STREAM, WAIT_DEC, DONE.
REQ-019 SHALL: IDLE -> WAIT_RDY on start; clears blk_sent and the decoded-block counter.
REQ-020 SHALL: WAIT_RDY -> PRIME when buf_ready = 1, sampled on the rising edge.
REQ-021 SHALL: PRIME lasts exactly RD_LAT cycles with rom_addr = 0 and buffer_valid = 0.
REQ-022 SHALL: STREAM runs a beat counter 0..FRAME_LEN-1, with buffer_valid = 1 on every beat.
REQ-023 SHALL: buffer_start = 1 only on beat 0; buffer_last = 1 only on beat FRAME_LEN-1.
REQ-024 SHALL: sub_x = section containing the current beat (beats 0-15 -> 0, 16-31 -> 1, 32-47 -> 2, 48-175 -> 3).
REQ-025 SHALL: during STREAM, rom_addr = section of (beat + RD_LAT), saturated at SUBX_NUM-1, so ROM data aligns with sub_x.
REQ-026 SHALL: after the last beat, blk_sent increments; the FSM goes to WAIT_RDY if blk_sent < BLK_NUM, else to WAIT_DEC.
REQ-027 SHALL: the decoded-block counter increments on each dec_valid in any busy state and saturates at BLK_NUM.
REQ-028 SHALL: WAIT_DEC -> DONE once the decoded-block counter = BLK_NUM, including a dec_valid arriving in the same cycle.
REQ-029 SHALL: DONE -> WAIT_RDY on start (new run, counters cleared); DONE holds otherwise.
REQ-030 SHALL: buf_ready deassertion during PRIME or STREAM is ignored; a started frame always completes.
REQ-031 SHALL: start while busy is ignored.
REQ-032 SHALL: abort forces IDLE on the next edge from any state, with all qualifiers at 0 that cycle; abort wins over start.
REQ-033 SHALL: all outputs are registered, with no combinational path from inputs to outputs.

Reset
REQ-034 SHALL: on rst_n low, state = IDLE, all outputs and counters = 0, asynchronously.
REQ-035 SHALL: reset mid-frame drops the frame; there is no partial resume after release.

Configuration
REQ-036 SHALL: macro APPMSG_STALL_CNT_EN, when defined, adds output stall_cnt (16 bits) counting WAIT_RDY cycles in the current run, saturating at 0xFFFF and cleared on start or reset.
REQ-037 SHALL: without APPMSG_STALL_CNT_EN, the stall_cnt port and its logic are absent, and all other behaviour is identical.

Verification
REQ-038 SHALL: start with buf_ready = 1 and defaults -> first buffer_valid 1+1+2 cycles after start; 176 valid beats; start on beat 0; last on beat 175; sub_x changes at beats 16, 32 and 48.
REQ-039 SHALL: ROM model with RD_LAT = 2 returning its address -> ROM data equals sub_x on every valid beat; repeat with RD_LAT = 1 and 3.
REQ-040 SHALL: buf_ready low for 10 cycles between frames -> no valid beats in the gap, blk_sent steps 1..8, and WAIT_DEC is entered after frame 8.
REQ-041 SHALL: 8 dec_valid pulses, the 8th coinciding with the last beat of frame 8 -> done = 1 the cycle after WAIT_DEC entry and busy = 0.
REQ-042 SHALL: abort on beat 100 of frame 3 -> buffer_valid = 0 next cycle, state IDLE, done = 0; a following start restarts with blk_sent = 0.
REQ-043 SHALL: with APPMSG_STALL_CNT_EN, 5 stall cycles before each of 8 frames -> stall_cnt = 40 at done; without the macro, the build elaborates with no stall_cnt port.
